prefetch_queue: RTL and testbench

- Parametrised successor to the byte-wide instruction prefetcher.
- Fetches BUS_BYTES-wide aligned words from memory using CS:IP with 16-bit IP wrap, and writes the valid byte lanes into an internal byte FIFO in one cycle.
- Presents one instruction byte per cycle, together with the IP of that byte, to the decoder.
- A branch (load_new_ip) flushes the queue and aborts or discards any in-flight fetch.

---
 rtl/prefetch_queue.sv | 131 +++++++++++++
 tb/tb_prefetch_queue.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/prefetch_queue.sv
// Instruction prefetch queue: fetches BUS_BYTES-wide aligned words at CS:IP into a
// byte FIFO and hands the decoder one byte per cycle along with that byte's IP.
module prefetch_queue #(
  parameter int          BUS_BYTES  = 2,
  parameter int          FIFO_DEPTH = 8,
  parameter logic [15:0] RESET_CS   = 16'hffff,
  parameter logic [15:0] RESET_IP   = 16'h0000
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic [15:0]                     new_cs,
  input  logic [15:0]                     new_ip,
  input  logic                            load_new_ip,
  input  logic                            rd_en,
  output logic [7:0]                      rd_data,
  output logic [15:0]                     rd_ip,
  output logic                            empty,
  output logic [$clog2(FIFO_DEPTH):0]     fifo_count,
  output logic                            mem_access,
  input  logic                            mem_ack,
  output logic [19-$clog2(BUS_BYTES):0]   mem_address,
  input  logic [8*BUS_BYTES-1:0]          mem_data
);

  localparam int OFF_W = $clog2(BUS_BYTES);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] BUS_CNT   = CNT_W'(BUS_BYTES);
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, FETCH, ABORT} state_t;

  state_t             state, state_next;
  logic [15:0]        cs, fetch_ip, pend_cs, pend_ip;
  logic [PTR_W-1:0]   wr_ptr, rd_ptr;
  logic [CNT_W-1:0]   count, count_next, n_write, free_now, free_next;
  logic [7:0]         buffer [FIFO_DEPTH];
  logic [19:0]        linear;
  logic [OFF_W-1:0]   off;
  logic               pop, accept;

  assign linear      = {cs, 4'b0000} + {4'b0000, fetch_ip};
  assign mem_address = linear[19:OFF_W];
  assign off         = fetch_ip[OFF_W-1:0];
  assign mem_access  = (state != IDLE);
  assign empty       = (count == '0);
  assign fifo_count  = count;
  assign rd_data     = empty ? 8'h00 : buffer[rd_ptr];

  always_comb begin
    pop        = rd_en && !empty;
    accept     = (state == FETCH) && mem_ack && !load_new_ip;
    n_write    = accept ? (BUS_CNT - CNT_W'(off)) : '0;
    count_next = count + n_write - CNT_W'(pop);
    free_now   = DEPTH_CNT - count;
    free_next  = DEPTH_CNT - count_next;
    state_next = state;
    case (state)
      IDLE: begin
        if (!load_new_ip && (free_now >= BUS_CNT))
          state_next = FETCH;
      end
      FETCH: begin
        if (load_new_ip && mem_ack)
          state_next = IDLE;
        else if (load_new_ip)
          state_next = ABORT;
        else if (mem_ack)
          state_next = (free_next >= BUS_CNT) ? FETCH : IDLE;
      end
      ABORT: begin
        if (mem_ack)
          state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // A branch while a fetch is still outstanding parks the target until the stale ack arrives
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      cs       <= RESET_CS;
      fetch_ip <= RESET_IP;
      pend_cs  <= RESET_CS;
      pend_ip  <= RESET_IP;
      rd_ip    <= RESET_IP;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
    end else begin
      state <= state_next;
      if (load_new_ip) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
        rd_ip  <= new_ip;
        if ((state != IDLE) && !mem_ack) begin
          pend_cs <= new_cs;
          pend_ip <= new_ip;
        end else begin
          cs       <= new_cs;
          fetch_ip <= new_ip;
        end
      end else begin
        count  <= count_next;
        wr_ptr <= wr_ptr + n_write[PTR_W-1:0];
        rd_ptr <= rd_ptr + PTR_W'(pop);
        if (pop)
          rd_ip <= rd_ip + 16'd1;
        if (accept)
          fetch_ip <= fetch_ip + 16'(BUS_BYTES) - 16'(off);
        if ((state == ABORT) && mem_ack) begin
          cs       <= pend_cs;
          fetch_ip <= pend_ip;
        end
      end
    end
  end

  // Byte storage needs no reset; occupancy alone decides what is visible
  always_ff @(posedge clk) begin
    if (accept) begin
      for (int k = 0; k < BUS_BYTES; k++) begin
        if (k >= int'(off))
          buffer[wr_ptr + PTR_W'(k) - PTR_W'(off)] <= mem_data[8*k +: 8];
      end
    end
  end

endmodule

// File: tb/tb_prefetch_queue.sv
// Directed bench for prefetch_queue with a 4-byte bus and an 8-byte queue.
module tb_prefetch_queue;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [15:0] new_cs, new_ip;
  logic        load_new_ip, rd_en, mem_ack;
  logic [31:0] mem_data;
  logic [7:0]  rd_data;
  logic [15:0] rd_ip;
  logic        empty, mem_access;
  logic [3:0]  fifo_count;
  logic [17:0] mem_address;

  int checks = 0;
  int errors = 0;

  prefetch_queue #(.BUS_BYTES(4), .FIFO_DEPTH(8), .RESET_CS(16'hffff), .RESET_IP(16'h0000)) dut (
    .clk(clk), .reset_n(reset_n), .new_cs(new_cs), .new_ip(new_ip),
    .load_new_ip(load_new_ip), .rd_en(rd_en), .rd_data(rd_data), .rd_ip(rd_ip),
    .empty(empty), .fifo_count(fifo_count), .mem_access(mem_access),
    .mem_ack(mem_ack), .mem_address(mem_address), .mem_data(mem_data)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    int n;
    reset_n = 1'b0; load_new_ip = 1'b0; rd_en = 1'b0; mem_ack = 1'b0;
    new_cs = '0; new_ip = '0; mem_data = '0;
    tick(); tick();
    checks++; if (mem_access !== 1'b0) begin errors++; $display("[TB] FAIL reset_access got %b want 0", mem_access); end
    checks++; if (empty !== 1'b1 || fifo_count !== 4'd0) begin errors++; $display("[TB] FAIL reset_empty got %b/%0d want 1/0", empty, fifo_count); end
    checks++; if (rd_ip !== 16'h0000 || rd_data !== 8'h00) begin errors++; $display("[TB] FAIL reset_head got %h/%h want 0000/00", rd_ip, rd_data); end
    reset_n = 1'b1;
    n = 0;
    while (!mem_access && n < 3) begin tick(); n++; end
    checks++; if (mem_access !== 1'b1) begin errors++; $display("[TB] FAIL first_issue got %b want 1 within 2 edges", mem_access); end
    checks++; if (mem_address !== 18'h3fffc) begin errors++; $display("[TB] FAIL first_addr got %h want 3fffc", mem_address); end
    mem_ack = 1'b1; mem_data = 32'h44332211;
    tick();
    mem_ack = 1'b0;
    checks++; if (fifo_count !== 4'd4 || rd_data !== 8'h11 || rd_ip !== 16'h0000) begin errors++; $display("[TB] FAIL first_fill got %0d/%h/%h want 4/11/0000", fifo_count, rd_data, rd_ip); end
    checks++; if (mem_access !== 1'b1 || mem_address !== 18'h3fffd) begin errors++; $display("[TB] FAIL second_addr got %b/%h want 1/3fffd", mem_access, mem_address); end
  endtask

  task automatic test_full_and_pop();
    logic [7:0] exp_bytes [4];
    exp_bytes = '{8'h11, 8'h22, 8'h33, 8'h44};
    mem_ack = 1'b1; mem_data = 32'h88776655;
    tick();
    mem_ack = 1'b0;
    checks++; if (fifo_count !== 4'd8 || mem_access !== 1'b0) begin errors++; $display("[TB] FAIL full_idle got %0d/%b want 8/0", fifo_count, mem_access); end
    tick();
    checks++; if (mem_access !== 1'b0) begin errors++; $display("[TB] FAIL full_stays_idle got %b want 0", mem_access); end
    rd_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      checks++; if (rd_data !== exp_bytes[i] || rd_ip !== 16'(i)) begin errors++; $display("[TB] FAIL pop_%0d got %h/%h want %h/%h", i, rd_data, rd_ip, exp_bytes[i], 16'(i)); end
      tick();
    end
    rd_en = 1'b0;
    checks++; if (fifo_count !== 4'd5 || mem_access !== 1'b0) begin errors++; $display("[TB] FAIL pop3_idle got %0d/%b want 5/0", fifo_count, mem_access); end
    tick();
    checks++; if (mem_access !== 1'b0) begin errors++; $display("[TB] FAIL pop3_still_idle got %b want 0", mem_access); end
    checks++; if (rd_data !== 8'h44 || rd_ip !== 16'h0003) begin errors++; $display("[TB] FAIL pop4_head got %h/%h want 44/0003", rd_data, rd_ip); end
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    checks++; if (fifo_count !== 4'd4 || mem_access !== 1'b0) begin errors++; $display("[TB] FAIL pop4_edge got %0d/%b want 4/0", fifo_count, mem_access); end
    tick();
    checks++; if (mem_access !== 1'b1 || mem_address !== 18'h3fffe) begin errors++; $display("[TB] FAIL refill_issue got %b/%h want 1/3fffe", mem_access, mem_address); end
  endtask

  task automatic test_abort();
    load_new_ip = 1'b1; new_cs = 16'h3000; new_ip = 16'h0020;
    tick();
    checks++; if (empty !== 1'b1 || fifo_count !== 4'd0 || mem_access !== 1'b1) begin errors++; $display("[TB] FAIL abort_flush got %b/%0d/%b want 1/0/1", empty, fifo_count, mem_access); end
    new_cs = 16'h2000; new_ip = 16'h0010;
    tick();
    load_new_ip = 1'b0;
    checks++; if (rd_ip !== 16'h0010 || mem_access !== 1'b1) begin errors++; $display("[TB] FAIL abort_reload got %h/%b want 0010/1", rd_ip, mem_access); end
    tick();
    mem_ack = 1'b1; mem_data = 32'hdeadbeef;
    tick();
    mem_ack = 1'b0;
    checks++; if (empty !== 1'b1 || fifo_count !== 4'd0 || mem_access !== 1'b0) begin errors++; $display("[TB] FAIL abort_discard got %b/%0d/%b want 1/0/0", empty, fifo_count, mem_access); end
    tick();
    checks++; if (mem_access !== 1'b1 || mem_address !== 18'h08004 || rd_ip !== 16'h0010) begin errors++; $display("[TB] FAIL abort_target got %b/%h/%h want 1/08004/0010", mem_access, mem_address, rd_ip); end
  endtask

  task automatic test_back_to_back();
    mem_ack = 1'b1; mem_data = 32'h04030201;
    tick();
    mem_ack = 1'b0;
    checks++; if (fifo_count !== 4'd4 || rd_data !== 8'h01 || rd_ip !== 16'h0010) begin errors++; $display("[TB] FAIL pre_coincide got %0d/%h/%h want 4/01/0010", fifo_count, rd_data, rd_ip); end
    load_new_ip = 1'b1; new_cs = 16'h1000; new_ip = 16'h0003;
    mem_ack = 1'b1; mem_data = 32'hcafef00d; rd_en = 1'b1;
    tick();
    load_new_ip = 1'b0; mem_ack = 1'b0; rd_en = 1'b0;
    checks++; if (fifo_count !== 4'd0 || empty !== 1'b1 || rd_ip !== 16'h0003) begin errors++; $display("[TB] FAIL coincide_flush got %0d/%b/%h want 0/1/0003", fifo_count, empty, rd_ip); end
    checks++; if (mem_access !== 1'b0) begin errors++; $display("[TB] FAIL coincide_no_abort got %b want 0", mem_access); end
    tick();
    checks++; if (mem_access !== 1'b1 || mem_address !== 18'h04000) begin errors++; $display("[TB] FAIL coincide_issue got %b/%h want 1/04000", mem_access, mem_address); end
    mem_ack = 1'b1; mem_data = 32'h44332211;
    tick();
    mem_ack = 1'b0;
    checks++; if (fifo_count !== 4'd1 || rd_data !== 8'h44 || rd_ip !== 16'h0003) begin errors++; $display("[TB] FAIL partial_lane got %0d/%h/%h want 1/44/0003", fifo_count, rd_data, rd_ip); end
    checks++; if (mem_access !== 1'b1 || mem_address !== 18'h04001) begin errors++; $display("[TB] FAIL partial_next got %b/%h want 1/04001", mem_access, mem_address); end
  endtask

  task automatic test_ip_wrap();
    mem_ack = 1'b1; mem_data = 32'h08070605;
    tick();
    mem_ack = 1'b0;
    checks++; if (fifo_count !== 4'd5 || mem_access !== 1'b0) begin errors++; $display("[TB] FAIL wrap_pre_idle got %0d/%b want 5/0", fifo_count, mem_access); end
    load_new_ip = 1'b1; new_cs = 16'h0000; new_ip = 16'hfffe;
    tick();
    load_new_ip = 1'b0;
    checks++; if (fifo_count !== 4'd0 || mem_access !== 1'b0 || rd_ip !== 16'hfffe) begin errors++; $display("[TB] FAIL idle_load got %0d/%b/%h want 0/0/fffe", fifo_count, mem_access, rd_ip); end
    tick();
    checks++; if (mem_access !== 1'b1 || mem_address !== 18'h03fff) begin errors++; $display("[TB] FAIL wrap_issue got %b/%h want 1/03fff", mem_access, mem_address); end
    mem_ack = 1'b1; mem_data = 32'hddccbbaa;
    tick();
    mem_ack = 1'b0;
    checks++; if (fifo_count !== 4'd2 || rd_data !== 8'hcc || rd_ip !== 16'hfffe) begin errors++; $display("[TB] FAIL wrap_lanes got %0d/%h/%h want 2/cc/fffe", fifo_count, rd_data, rd_ip); end
    checks++; if (mem_access !== 1'b1 || mem_address !== 18'h00000) begin errors++; $display("[TB] FAIL wrap_same_seg got %b/%h want 1/00000", mem_access, mem_address); end
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    checks++; if (rd_data !== 8'hdd || rd_ip !== 16'hffff) begin errors++; $display("[TB] FAIL wrap_second got %h/%h want dd/ffff", rd_data, rd_ip); end
    load_new_ip = 1'b1; new_cs = 16'hffff; new_ip = 16'h0010;
    tick();
    load_new_ip = 1'b0;
    mem_ack = 1'b1; mem_data = 32'h12345678;
    tick();
    mem_ack = 1'b0;
    tick();
    checks++; if (mem_access !== 1'b1 || mem_address !== 18'h00000 || empty !== 1'b1) begin errors++; $display("[TB] FAIL linear_wrap got %b/%h/%b want 1/00000/1", mem_access, mem_address, empty); end
  endtask

  task automatic test_reset_mid_access();
    reset_n = 1'b0;
    #1;
    checks++; if (mem_access !== 1'b0 || fifo_count !== 4'd0) begin errors++; $display("[TB] FAIL async_reset got %b/%0d want 0/0", mem_access, fifo_count); end
    #1;
    reset_n = 1'b1;
    mem_ack = 1'b1; mem_data = 32'h55aa55aa;
    tick();
    mem_ack = 1'b0;
    checks++; if (fifo_count !== 4'd0 || empty !== 1'b1) begin errors++; $display("[TB] FAIL late_ack got %0d/%b want 0/1", fifo_count, empty); end
    checks++; if (mem_access !== 1'b1 || mem_address !== 18'h3fffc || rd_ip !== 16'h0000) begin errors++; $display("[TB] FAIL post_reset got %b/%h/%h want 1/3fffc/0000", mem_access, mem_address, rd_ip); end
  endtask

  initial begin
    test_reset();
    test_full_and_pop();
    test_abort();
    test_back_to_back();
    test_ip_wrap();
    test_reset_mid_access();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
